// File: rtl/rs_latch_driver_if.sv
// rs_latch_driver_if: request/status bundle between a client
// (master) and rs_latch_driver (slave).
// Fields: req_valid/req_val/req_ready handshake, done pulse,
// sticky err, state_q tracked latch contents.
interface rs_latch_driver_if;
  logic req_valid;
  logic req_val;
  logic req_ready;
  logic done;
  logic err;
  logic state_q;

  modport master (
    output req_valid, req_val,
    input  req_ready, done, err, state_q
  );

  modport slave (
    input  req_valid, req_val,
    output req_ready, done, err, state_q
  );
endinterface

// File: rtl/rs_latch_driver.sv
// rs_latch_driver: write controller for a NOR RS latch; one-hot
// r/s pulse, settle window, optional readback (RS_DRV_VERIFY_EN).
// Ports: clk, reset (sync, active-high), bus (slave: req_valid,
// req_val, req_ready, done, err, state_q), r, s (registered latch
// drive), q_in, qb_in (latch readback).
module rs_latch_driver #(
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  rs_latch_driver_if.slave bus,
  output logic r,
  output logic s,
  input  logic q_in,
  input  logic qb_in
);

  localparam int MAX_CYC =
    (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    INIT, IDLE, PULSE, SETTLE, CHECK
  } state_t;

  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          val, val_n;
  logic          boot, boot_n;
  logic          r_n, s_n;
  logic          sq;

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= INIT;
      cnt  <= PULSE_LD;
      val  <= 1'b0;
      boot <= 1'b1;
      r    <= 1'b1;
      s    <= 1'b0;
      sq   <= 1'b0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      val  <= val_n;
      boot <= boot_n;
      r    <= r_n;
      s    <= s_n;
      if (st == CHECK) sq <= val;
    end
  end

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    val_n  = val;
    boot_n = boot;
    unique case (st)
      INIT, PULSE: begin
        if (cnt == ONE) begin
          st_n  = SETTLE;
          cnt_n = SETTLE_LD;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      IDLE: begin
        if (bus.req_valid) begin
          st_n   = PULSE;
          cnt_n  = PULSE_LD;
          val_n  = bus.req_val;
          boot_n = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt == ONE) st_n = CHECK;
        else            cnt_n = cnt - ONE;
      end
      CHECK:   st_n = IDLE;
      default: st_n = INIT;
    endcase
  end

  // r/s are decoded from the next state so the registered
  // drive lines up with the state; the two terms are exclusive.
  always_comb begin
    r_n = (st_n == INIT) || ((st_n == PULSE) && !val_n);
    s_n = (st_n == PULSE) && val_n;
  end

  assign bus.req_ready = (st == IDLE);
  assign bus.done      = (st == CHECK) && !boot;
  assign bus.state_q   = sq;

`ifdef RS_DRV_VERIFY_EN
  logic mism;
  logic err_q;

  // q==qb catches a latch stuck in the forbidden/metastable pair.
  assign mism = (q_in != val) || (qb_in != ~val)
             || (q_in == qb_in);

  always_ff @(posedge clk) begin
    if (reset)                     err_q <= 1'b0;
    else if ((st == CHECK) && mism) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  logic unused_rb;
  assign unused_rb = q_in ^ qb_in;
  assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_rs_latch_driver.sv
// tb_rs_latch_driver: scoreboard bench with a NOR latch model.
// Main issues requests; monitor checks pulses, done and status.
module tb_rs_latch_driver;
  localparam int P = 2;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset;
  logic r, s, q_in, qb_in;
  bit   q_m;
  bit   force_bad;

  rs_latch_driver_if bus();

  rs_latch_driver #(
    .PULSE_CYC(P),
    .SETTLE_CYC(S)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .r    (r),
    .s    (s),
    .q_in (q_in),
    .qb_in(qb_in)
  );

  always #5 clk = ~clk;

  always @(r or s) begin
    if (r)      q_m = 1'b0;
    else if (s) q_m = 1'b1;
  end

  assign q_in  = force_bad ? 1'b0 : q_m;
  assign qb_in = force_bad ? 1'b1 : ~q_m;

  typedef struct {
    bit v;
    int a;
    bit e;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   idle_at = 0;
  bit   err_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic reset_seq();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_r", int'(r), 1);
    chk("rst_s", int'(s), 0);
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_state_q", int'(bus.state_q), 0);
    @(negedge clk);
    reset   = 1'b0;
    err_m   = 1'b0;
    idle_at = cyc + 1 + P + S;
    for (int k = 0; k <= P + S; k++) begin
      @(posedge clk);
      #1;
      chk("init_r", int'(r), int'(k < P - 1));
      chk("init_s", int'(s), 0);
      chk("init_ready", int'(bus.req_ready),
          int'(k == P + S));
    end
    chk("init_q", int'(q_m), 0);
    chk("init_state_q", int'(bus.state_q), 0);
    chk("init_err", int'(bus.err), 0);
  endtask

  task automatic do_req(input bit v, input bit hold);
    int k;
    int a;
    int pa;
    @(negedge clk);
    pa = (cyc > idle_at) ? cyc + 1 : idle_at + 1;
    bus.req_valid = 1'b1;
    bus.req_val   = v;
    k = 0;
    while (!bus.req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", int'(bus.req_ready), 1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    a = cyc + 1;
    chk("accept_cyc", a, pa);
`ifdef RS_DRV_VERIFY_EN
    if (force_bad && v) err_m = 1'b1;
`endif
    sb.push_back('{v, a, err_m});
    idle_at = a + P + S + 1;
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    bit   pend;
    exp_t e;
    exp_t pe;
    forever begin
      @(posedge clk);
      #1;
      chk("rs_excl", int'(r && s), 0);
      chk("done_ready", int'(bus.done && bus.req_ready), 0);
      if (pend) begin
        pend = 1'b0;
        chk("post_ready", int'(bus.req_ready), 1);
        chk("post_state_q", int'(bus.state_q), int'(pe.v));
        chk("post_err", int'(bus.err), int'(pe.e));
        chk("post_q", int'(q_m), int'(pe.v));
      end
      if (sb.size() > 0) begin
        e = sb[0];
        if (cyc >= e.a && cyc < e.a + P) begin
          chk("pulse_s", int'(s), int'(e.v));
          chk("pulse_r", int'(r), int'(!e.v));
        end else if (cyc >= e.a + P && cyc < e.a + P + S) begin
          chk("settle_r", int'(r), 0);
          chk("settle_s", int'(s), 0);
        end
        if (cyc == e.a + P + S) begin
          chk("done", int'(bus.done), 1);
          void'(sb.pop_front());
          pe   = e;
          pend = 1'b1;
        end else begin
          chk("spurious_done", int'(bus.done), 0);
        end
      end else begin
        chk("spurious_done", int'(bus.done), 0);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_val   = 1'b0;
    force_bad     = 1'b0;
    repeat (2) @(negedge clk);
    reset_seq();

    do_req(1'b1, 1'b0);
    wait_idle();

    do_req(1'b1, 1'b1);
    do_req(1'b0, 1'b0);
    wait_idle();
    chk("b2b_state_q", int'(bus.state_q), 0);
    chk("b2b_q", int'(q_m), 0);

    force_bad = 1'b1;
    do_req(1'b1, 1'b0);
    wait_idle();
    force_bad = 1'b0;
    do_req(1'b0, 1'b0);
    do_req(1'b1, 1'b0);
    wait_idle();

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_val   = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("abort_accept", int'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("abort_s1", int'(s), 1);
    @(posedge clk);
    #1;
    chk("abort_s2", int'(s), 1);
    reset_seq();

    do_req(1'b1, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
